// File: rtl/regfile_mp.sv
// 2-write/2-read register file with fixed write priority, optional r0 hardwiring and a sequenced bulk-clear engine.
// Define REGFILE_BYPASS_EN to make reads return the value each entry will hold after the next edge.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  input  logic          we0,
  input  logic [AW-1:0] wn0,
  input  logic [DW-1:0] d0,
  input  logic          we1,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d1,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          clear_done
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          last;

  assign last = (ptr == '1);

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear_req) state_nx = CLEAR;
      CLEAR:   if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state == CLEAR);
    clear_done = (state == DONE);
  end

  // Later assignments win: port 1 overrides port 0, clear overrides both.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '{default: '0};
      ptr <= '0;
    end else begin
      if (we0 && !(ZERO_REG != 0 && wn0 == '0)) mem[wn0] <= d0;
      if (we1 && !(ZERO_REG != 0 && wn1 == '0)) mem[wn1] <= d1;
      if (state == CLEAR) begin
        mem[ptr] <= '0;
        if (!last) ptr <= ptr + 1'b1;
      end else if (state == IDLE && clear_req) begin
        ptr <= '0;
      end
    end
  end

  function automatic logic [DW-1:0] lookup(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    if (!clr) begin
      if (we0 && wn0 == a)               v = d0;
      if (we1 && wn1 == a)               v = d1;
      if (state == CLEAR && ptr == a)    v = '0;
    end
`endif
    if (ZERO_REG != 0 && a == '0) v = '0;
    return v;
  endfunction

  always_comb qa = lookup(rna);
  always_comb qb = lookup(rnb);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          clr, we0, we1, clear_req;
  logic [AW-1:0] rna, rnb, wn0, wn1;
  logic [DW-1:0] d0, d1, qa, qb;
  logic          clear_busy, clear_done;

  regfile_mp #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .we0(we0), .wn0(wn0), .d0(d0), .we1(we1), .wn1(wn1), .d1(d1),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: contents plus clear progress (-1 idle, 0..DEPTH-1 entry being cleared, DEPTH done pulse).
  logic [DW-1:0] model [DEPTH];
  int            phase = -1;
  logic          obs_busy, obs_done;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    if (!clr) begin
      if (we0 && wn0 == a) v = d0;
      if (we1 && wn1 == a) v = d1;
      if (phase >= 0 && phase < DEPTH && int'(a) == phase) v = '0;
    end
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  task automatic model_edge();
    if (clr) begin
      foreach (model[i]) model[i] = '0;
      phase = -1;
    end else begin
      if (we0 && wn0 != 0) model[wn0] = d0;
      if (we1 && wn1 != 0) model[wn1] = d1;
      if (phase >= 0 && phase < DEPTH) begin
        model[phase] = '0;
        phase = phase + 1;
      end else if (phase == DEPTH) begin
        phase = -1;
      end else if (clear_req) begin
        phase = 0;
      end
    end
  endtask

  // Inputs must already be driven; checks mid-cycle, then advances one edge.
  task automatic cycle();
    #1;
    obs_busy = clear_busy;
    obs_done = clear_done;
    check("qa", qa, expect_rd(rna));
    check("qb", qb, expect_rd(rnb));
    check("busy", {31'd0, clear_busy}, {31'd0, phase >= 0 && phase < DEPTH});
    check("done", {31'd0, clear_done}, {31'd0, phase == DEPTH});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    clr = 0; we0 = 0; we1 = 0; clear_req = 0;
    wn0 = '0; wn1 = '0; d0 = '0; d1 = '0;
  endtask

  task automatic fill_inc();
    quiet();
    for (int i = 0; i < DEPTH; i++) begin
      we0 = 1; wn0 = AW'(i); d0 = DW'(i + 1); rna = AW'(i); rnb = AW'(i);
      cycle();
    end
    quiet();
  endtask

  int busy_n, done_n, done_at;

  initial begin
    quiet();
    rna = '0; rnb = '0;
    clr = 1;
    @(posedge clk); model_edge(); #1;
    clr = 0;

    // 1: random fill, single clr edge, sweep all entries.
    for (int i = 0; i < DEPTH; i++) begin
      we0 = 1; wn0 = AW'(i); d0 = $urandom;
      we1 = 1; wn1 = AW'($urandom_range(0, DEPTH - 1)); d1 = $urandom;
      cycle();
    end
    quiet(); clr = 1; cycle(); clr = 0;
    for (int i = 0; i < DEPTH; i += 2) begin
      rna = AW'(i); rnb = AW'(i + 1);
      cycle();
      check("clr_zero", qa | qb, '0);
    end

    // 2: same-address dual write, port 1 wins.
    we0 = 1; wn0 = 5; d0 = 32'hAAAA0000;
    we1 = 1; wn1 = 5; d1 = 32'h5555FFFF; rna = 5;
    cycle();
    quiet(); rna = 5; cycle();
    check("prio", qa, 32'h5555FFFF);

    // 3: entry 0 ignores writes.
    we0 = 1; wn0 = 0; d0 = 32'hFFFFFFFF; rna = 0;
    cycle();
    quiet(); rna = 0; cycle();
    check("r0", qa, '0);

    // 6: same-cycle visibility of a write.
    quiet(); we0 = 1; wn0 = 7; d0 = 32'h0BAD; cycle();
    quiet(); we1 = 1; wn1 = 7; d1 = 32'h1234; rna = 7; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass", qa, 32'h1234);
`else
    check("nobypass", qa, 32'h0BAD);
`endif
    cycle();

    // 4: full clear with a write behind the pointer.
    fill_inc();
    clear_req = 1; cycle(); clear_req = 0;
    busy_n = 0; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      quiet();
      rna = AW'(n); rnb = 3;
      if (n == 11) begin we0 = 1; wn0 = 3; d0 = 32'h77; end
      cycle();
      if (obs_busy) busy_n++;
      if (obs_done && done_at < 0) done_at = n;
    end
    check("busy_len", DW'(busy_n), DW'(DEPTH));
    check("done_at", DW'(done_at), DW'(DEPTH + 1));
    quiet(); rna = 3; rnb = 4; cycle();
    check("kept3", qa, 32'h77);
    check("zero4", qb, '0);

    // 5: clr in the middle of a clear.
    fill_inc();
    clear_req = 1; cycle(); clear_req = 0;
    done_n = 0;
    for (int n = 1; n <= 40; n++) begin
      quiet();
      rna = AW'(n); rnb = AW'(n + 16);
      if (n == 17) clr = 1;
      cycle();
      if (n == 18) check("busy_drop", {31'd0, obs_busy}, '0);
      if (obs_done) done_n++;
    end
    check("no_done", DW'(done_n), '0);

    // Held request restarts on the IDLE cycle after DONE.
    quiet(); clear_req = 1; done_n = 0;
    for (int n = 0; n < 70; n++) begin
      rna = AW'($urandom); rnb = AW'($urandom);
      cycle();
      if (obs_done) done_n++;
    end
    check("restart", DW'(done_n), 32'd2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 99) == 0);
      clear_req = ($urandom_range(0, 19) == 0);
      we0 = $urandom; wn0 = AW'($urandom); d0 = $urandom;
      we1 = $urandom; wn1 = ($urandom_range(0, 3) == 0) ? wn0 : AW'($urandom); d1 = $urandom;
      rna = ($urandom_range(0, 3) == 0) ? wn1 : AW'($urandom);
      rnb = AW'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
